// File: rtl/wb_port_sched.sv
// Register-file write-port scheduler: WB stage has priority over a one-deep long-latency result buffer.
// Define WB_PERF_EN to build the blocked-cycle performance counter behind conflict_cnt.
module wb_port_sched #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [31:0] Instr_WB,
    input  logic [1:0]  wb_wasel,
    input  logic [31:0] wb_data,
    input  logic        lr_valid,
    input  logic [4:0]  lr_wa,
    input  logic [31:0] lr_data,
    output logic        lr_ready,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [15:0] conflict_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;
    localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [1:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        buf_full, buf_full_nxt;
    logic [4:0]  buf_wa;
    logic [31:0] buf_data;

    logic [4:0]  wb_wa;
    logic        wb_we;
    logic        lr_acc;
    logic        buf_grant;
    logic        stale_drop;

    logic        sel_we_p0;
    logic [4:0]  sel_wa_p0;
    logic [31:0] sel_wd_p0;

    // Only the rd/rt fields of the WB instruction matter here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr_WB[31:21], Instr_WB[10:0]};

    always_comb begin
        case (wb_wasel)
            2'b00:   wb_wa = Instr_WB[15:11];
            2'b01:   wb_wa = Instr_WB[20:16];
            2'b10:   wb_wa = 5'd31;
            default: wb_wa = 5'd0;
        endcase
    end

    assign wb_we      = wb_valid && (wb_wasel != 2'b11) && (wb_wa != 5'd0);
    assign lr_acc     = lr_valid && !buf_full && (lr_wa != 5'd0);
    assign buf_grant  = buf_full && !wb_we;
    // A younger WB write to the same register makes the buffered result dead.
    assign stale_drop = buf_full && wb_we && (wb_wa == buf_wa);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        buf_full_nxt = buf_full;
        case (state)
            S_IDLE: begin
                if (lr_acc) begin
                    state_nxt    = S_WAIT;
                    cnt_nxt      = 4'd0;
                    buf_full_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (buf_grant || stale_drop) begin
                    state_nxt    = S_IDLE;
                    buf_full_nxt = 1'b0;
                end else begin
                    cnt_nxt = sat_inc4(cnt);
                    if (cnt == CNT_LAST) state_nxt = S_FORCE;
                end
            end
            S_FORCE: begin
                if (buf_grant || stale_drop) begin
                    state_nxt    = S_IDLE;
                    buf_full_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                buf_full_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            buf_full <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            buf_full <= buf_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (lr_acc) begin
            buf_wa   <= lr_wa;
            buf_data <= lr_data;
        end
    end

    assign lr_ready  = ~buf_full;
    assign stall_req = (state == S_FORCE);

    // Port arbitration -> registered write port
    assign sel_we_p0 = wb_we || buf_grant;
    assign sel_wa_p0 = wb_we ? wb_wa   : buf_wa;
    assign sel_wd_p0 = wb_we ? wb_data : buf_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we <= 1'b0;
            rf_wa <= 5'd0;
            rf_wd <= 32'd0;
        end else begin
            rf_we <= sel_we_p0;
            if (sel_we_p0) begin
                rf_wa <= sel_wa_p0;
                rf_wd <= sel_wd_p0;
            end
        end
    end

`ifdef WB_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] perf_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cnt <= 16'd0;
        end else if (buf_full && wb_we) begin
            perf_cnt <= sat_inc16(perf_cnt);
        end
    end

    assign conflict_cnt = perf_cnt;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wb_port_sched.sv
// Directed bench for wb_port_sched: WB decode, LR buffering, starvation bubble, stale drop, resets.
module tb_wb_port_sched;

    logic        clk;
    logic        reset_n;
    logic        wb_valid;
    logic [31:0] Instr_WB;
    logic [1:0]  wb_wasel;
    logic [31:0] wb_data;
    logic        lr_valid;
    logic [4:0]  lr_wa;
    logic [31:0] lr_data;
    logic        lr_ready;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [15:0] conflict_cnt;

    int checks;
    int failures;

    wb_port_sched #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb_valid     (wb_valid),
        .Instr_WB     (Instr_WB),
        .wb_wasel     (wb_wasel),
        .wb_data      (wb_data),
        .lr_valid     (lr_valid),
        .lr_wa        (lr_wa),
        .lr_data      (lr_data),
        .lr_ready     (lr_ready),
        .stall_req    (stall_req),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
        checks++; if (rf_wa !== 5'd0) begin failures++; $display("FAIL reset_rf_wa got=%0h exp=0", rf_wa); end
        checks++; if (rf_wd !== 32'd0) begin failures++; $display("FAIL reset_rf_wd got=%0h exp=0", rf_wd); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_req); end
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL reset_lr_ready got=%0h exp=1", lr_ready); end
        checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL reset_conflict got=%0h exp=0", conflict_cnt); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wb_only();
        wb_valid = 1'b1; Instr_WB = 32'd5 << 11; wb_wasel = 2'b00; wb_data = 32'h1234;
        tick();
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL wb_rd_we got=%0h exp=1", rf_we); end
        checks++; if (rf_wa !== 5'd5) begin failures++; $display("FAIL wb_rd_wa got=%0d exp=5", rf_wa); end
        checks++; if (rf_wd !== 32'h1234) begin failures++; $display("FAIL wb_rd_wd got=%0h exp=1234", rf_wd); end
        wb_wasel = 2'b10; wb_data = 32'h55;
        tick();
        checks++; if (rf_wa !== 5'd31) begin failures++; $display("FAIL wb_ra_wa got=%0d exp=31", rf_wa); end
        checks++; if (rf_wd !== 32'h55) begin failures++; $display("FAIL wb_ra_wd got=%0h exp=55", rf_wd); end
        Instr_WB = (32'd12 << 16) | (32'd5 << 11); wb_wasel = 2'b01; wb_data = 32'h77;
        tick();
        checks++; if (rf_wa !== 5'd12) begin failures++; $display("FAIL wb_rt_wa got=%0d exp=12", rf_wa); end
        wb_wasel = 2'b11; wb_data = 32'h99;
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL wb_nowrite_we got=%0h exp=0", rf_we); end
        checks++; if (rf_wd !== 32'h77) begin failures++; $display("FAIL wb_nowrite_hold got=%0h exp=77", rf_wd); end
        Instr_WB = 32'd0; wb_wasel = 2'b00; wb_data = 32'hAA;
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL wb_r0_we got=%0h exp=0", rf_we); end
        wb_valid = 1'b0;
        tick();
    endtask

    task automatic test_lr_idle();
        lr_valid = 1'b1; lr_wa = 5'd7; lr_data = 32'hCAFE;
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL lr_idle_ready0 got=%0h exp=1", lr_ready); end
        tick();
        lr_valid = 1'b0;
        checks++; if (lr_ready !== 1'b0) begin failures++; $display("FAIL lr_idle_ready1 got=%0h exp=0", lr_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL lr_idle_we1 got=%0h exp=0", rf_we); end
        tick();
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL lr_idle_we2 got=%0h exp=1", rf_we); end
        checks++; if (rf_wa !== 5'd7) begin failures++; $display("FAIL lr_idle_wa got=%0d exp=7", rf_wa); end
        checks++; if (rf_wd !== 32'hCAFE) begin failures++; $display("FAIL lr_idle_wd got=%0h exp=cafe", rf_wd); end
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL lr_idle_ready2 got=%0h exp=1", lr_ready); end
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL lr_idle_we3 got=%0h exp=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        lr_valid = 1'b1; lr_wa = 5'd4; lr_data = 32'h44;
        tick();
        lr_wa = 5'd6; lr_data = 32'h66;
        checks++; if (lr_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready1 got=%0h exp=0", lr_ready); end
        tick();
        checks++; if (rf_wa !== 5'd4 || rf_we !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0h/%0d exp=1/4", rf_we, rf_wa); end
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%0h exp=1", lr_ready); end
        tick();
        lr_valid = 1'b0;
        checks++; if (lr_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready3 got=%0h exp=0", lr_ready); end
        tick();
        checks++; if (rf_wa !== 5'd6 || rf_wd !== 32'h66 || rf_we !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0h/%0d/%0h exp=1/6/66", rf_we, rf_wa, rf_wd); end
        tick();
    endtask

    task automatic test_starvation();
        lr_valid = 1'b1; lr_wa = 5'd10; lr_data = 32'hBEEF;
        wb_valid = 1'b1; Instr_WB = 32'd3 << 11; wb_wasel = 2'b00; wb_data = 32'h333;
        tick();
        lr_valid = 1'b0;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_stall_c1 got=%0h exp=0", stall_req); end
        checks++; if (rf_wa !== 5'd3 || rf_we !== 1'b1) begin failures++; $display("FAIL starve_wb_c1 got=%0h/%0d exp=1/3", rf_we, rf_wa); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_stall_c4 got=%0h exp=0", stall_req); end
        tick();
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL starve_stall_c5 got=%0h exp=1", stall_req); end
`ifdef WB_PERF_EN
        checks++; if (conflict_cnt !== 16'd4) begin failures++; $display("FAIL starve_conflict4 got=%0d exp=4", conflict_cnt); end
`else
        checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL starve_conflict_off got=%0d exp=0", conflict_cnt); end
`endif
        tick();
        tick();
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL starve_stall_c7 got=%0h exp=1", stall_req); end
        checks++; if (rf_wa !== 5'd3 || rf_wd !== 32'h333) begin failures++; $display("FAIL starve_wb_c7 got=%0d/%0h exp=3/333", rf_wa, rf_wd); end
        wb_valid = 1'b0;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd10 || rf_wd !== 32'hBEEF) begin failures++; $display("FAIL starve_lr_write got=%0h/%0d/%0h exp=1/10/beef", rf_we, rf_wa, rf_wd); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_stall_drop got=%0h exp=0", stall_req); end
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL starve_ready got=%0h exp=1", lr_ready); end
`ifdef WB_PERF_EN
        checks++; if (conflict_cnt !== 16'd6) begin failures++; $display("FAIL starve_conflict6 got=%0d exp=6", conflict_cnt); end
`endif
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL starve_idle_we got=%0h exp=0", rf_we); end
    endtask

    task automatic test_stale_drop();
        lr_valid = 1'b1; lr_wa = 5'd9; lr_data = 32'hDEAD;
        tick();
        lr_valid = 1'b0;
        wb_valid = 1'b1; Instr_WB = 32'd9 << 11; wb_wasel = 2'b00; wb_data = 32'h1;
        tick();
        wb_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'h1) begin failures++; $display("FAIL stale_wb got=%0h/%0d/%0h exp=1/9/1", rf_we, rf_wa, rf_wd); end
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL stale_ready got=%0h exp=1", lr_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (rf_we !== 1'b0 || rf_wd !== 32'h1) begin failures++; $display("FAIL stale_no_lr got=%0h/%0h exp=0/1", rf_we, rf_wd); end
        end
    endtask

    task automatic test_reset_mid_force();
        lr_valid = 1'b1; lr_wa = 5'd20; lr_data = 32'hF00D;
        wb_valid = 1'b1; Instr_WB = 32'd3 << 11; wb_wasel = 2'b00; wb_data = 32'h444;
        tick();
        lr_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL rst_force_entry got=%0h exp=1", stall_req); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rst_async_stall got=%0h exp=0", stall_req); end
        checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd0) begin failures++; $display("FAIL rst_async_rf got=%0h/%0d exp=0/0", rf_we, rf_wa); end
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%0h exp=1", lr_ready); end
        checks++; if (conflict_cnt !== 16'd0) begin failures++; $display("FAIL rst_async_conflict got=%0d exp=0", conflict_cnt); end
        wb_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rf_we !== 1'b0 || lr_ready !== 1'b1) begin failures++; $display("FAIL rst_no_lr got=%0h/%0h exp=0/1", rf_we, lr_ready); end
        end
    endtask

    task automatic test_zero_discard();
        lr_valid = 1'b1; lr_wa = 5'd0; lr_data = 32'hBAD;
        tick();
        lr_valid = 1'b0;
        checks++; if (lr_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0h exp=1", lr_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL zero_we got=%0h exp=0", rf_we); end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        wb_valid = 1'b0;
        Instr_WB = 32'd0;
        wb_wasel = 2'b00;
        wb_data  = 32'd0;
        lr_valid = 1'b0;
        lr_wa    = 5'd0;
        lr_data  = 32'd0;

        test_reset();
        test_wb_only();
        test_lr_idle();
        test_back_to_back();
        test_starvation();
        test_stale_drop();
        test_reset_mid_force();
        test_zero_discard();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_sched.md
# wb_port_sched

- Owns the single register-file write port at the writeback end of the pipeline.
- Two requesters share the port: the in-order WB stage and a long-latency result source (MDU/LR path, one-deep holding buffer).
- WB always has priority. A starvation counter forces a pipeline bubble when the LR result has waited too long.
- Also decodes the WB destination (rd / rt / $31) and registers the final rf_we/rf_wa/rf_wd driven into the register file.

## Interface
- STARVE_MAX, 4: consecutive blocked cycles before a bubble is forced; legal 1..15.
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  WB stage holds a register-writing instruction.
- Instr_WB  in  32  WB instruction; rd=[15:11], rt=[20:16].
- wb_wasel  in  2  destination select: 00 rd, 01 rt, 10 $31, 11 no write.
- wb_data  in  32  WB write data.
- lr_valid  in  1  long-latency result offered.
- lr_wa  in  5  long-latency destination register.
- lr_data  in  32  long-latency result data.
- lr_ready  out  1  holding buffer empty; transfer on lr_valid&&lr_ready at a rising edge.
- stall_req  out  1  asks the hazard unit to bubble MEM->WB.
- rf_we  out  1  register-file write enable, registered.
- rf_wa  out  5  register-file write address, registered.
- rf_wd  out  32  register-file write data, registered.
- conflict_cnt  out  16  blocked-cycle counter (see Configuration).

## Operation
- WB target wb_wa is decoded from wb_wasel. WB writes only if wb_valid=1, wb_wasel!=11 and wb_wa!=0.
- Holding buffer: buf_full, buf_wa, buf_data. lr_ready = ~buf_full (registered, no pass-through).
- An accepted LR result with lr_wa==0 is discarded. buf_full stays 0.
- FSM states:
  - IDLE: buffer empty.
    - LR accept with lr_wa!=0: load buffer, clear cnt, go WAIT.
  - WAIT: buffer full.
    - WB writes this cycle: WB granted, cnt++. At cnt==STARVE_MAX-1 go FORCE.
    - WB does not write: buffer granted, go IDLE.
  - FORCE: stall_req=1.
    - Buffer granted on the first cycle WB does not write, then go IDLE.
    - While WB keeps writing, WB still wins and the FSM stays in FORCE.
- Stale-result drop (WAIT or FORCE): when WB writes and wb_wa==buf_wa, the buffer is invalidated without writing and the FSM goes to IDLE. The WB instruction is younger, so its write is architecturally final.
- Grant selects {we,wa,wd} for the output register. With no grant, rf_we=0 and rf_wa/rf_wd hold their previous values.
- cnt is 4 bits, cleared on entry to WAIT, saturating.

## Timing
- Reset (async, reset_n=0) clears all state:
  - state=IDLE, buf_full=0, cnt=0.
  - rf_we=0, rf_wa=0, rf_wd=0, stall_req=0, lr_ready=1 (after reset), conflict_cnt=0.
- Reset mid-operation discards any buffered LR result.
- WB write: inputs at cycle t produce rf_* at cycle t+1 (1-cycle latency).
- LR write: accepted at edge ending cycle t → buf_full in t+1 → earliest rf_we in t+2.
- lr_ready rises the cycle after the buffer is granted. Maximum LR throughput is one result per 2 cycles.
- stall_req is a Moore output of FORCE. It is high from the cycle after the STARVE_MAX-th blocked cycle until the cycle after the grant.
- Simultaneous LR accept and buffer grant cannot occur, because lr_ready=0 while full.

## Configuration
- WB_PERF_EN defined:
  - conflict_cnt increments in every cycle the buffer is full and WB wins the port.
  - Saturates at 16'hFFFF; reset to 0.
- WB_PERF_EN undefined: conflict_cnt is tied to 0 and no counter flops exist.

## Test plan
- WB only: Instr_WB rd=5, wb_wasel=00, wb_data=32'h1234 → next cycle rf_we=1, rf_wa=5, rf_wd=32'h1234. With wasel=10 → rf_wa=31. With wasel=11 or rd=0 → rf_we=0.
- LR on idle port:
  - Stimulus: lr_wa=7, lr_data=32'hCAFE accepted at cycle 0, wb_valid=0.
  - Required: lr_ready=0 in cycle 1; rf_we=1, rf_wa=7, rf_wd=32'hCAFE in cycle 2; lr_ready=1 in cycle 2.
- Starvation, STARVE_MAX=4:
  - Stimulus: LR buffered; wb_valid=1 writing rd=3 every cycle.
  - Required: stall_req rises after 4 blocked cycles. On the first wb_valid=0 cycle, the LR write appears next cycle and stall_req drops. With WB_PERF_EN, conflict_cnt=4.
- Stale drop:
  - Stimulus: LR buffered for $9; WB writes $9 with 32'h1.
  - Required: rf_wa=9, rf_wd=32'h1; the buffered value is never written; lr_ready=1 next cycle.
- Reset mid-FORCE: assert reset_n=0 asynchronously → stall_req=0, rf_we=0, lr_ready=1 immediately; no LR write after release.
- $0 discard: LR with lr_wa=0 accepted → lr_ready stays 1 and rf_we never asserts for it.
